// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush controller for the five-stage pipeline: load-use bubbles, memory
// handshake freeze with timeout, taken-branch squash, and saturating event counters.
module pipeline_hazard_sequencer #(
   parameter int CNT_W    = 16,
   parameter int WAIT_MAX = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             memReadE,
   input  logic [4:0]       write_regE,
   input  logic [4:0]       read_reg1D,
   input  logic [4:0]       read_reg2D,
   input  logic             memReadM,
   input  logic             memWriteM,
   input  logic             mem_ready,
   input  logic             PCscr,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int WC_W = $clog2(WAIT_MAX + 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, ERROR} state_t;

   state_t            state_q, state_d;
   logic [WC_W-1:0]   waitCnt_q, waitCnt_d;
   logic [CNT_W-1:0]  stallCnt_q, flushCnt_q;
   logic              memPend, loadUse;

   assign memPend = (memReadM | memWriteM) & ~mem_ready;
   assign loadUse = memReadE & (write_regE != 5'd0) &
                    ((write_regE == read_reg1D) | (write_regE == read_reg2D));

   // Control outputs and next state are a pure function of state and inputs;
   // reset forces a full squash so nothing half-formed survives into RUN.
   always_comb begin
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      stallM    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      flushM    = 1'b0;
      timeout   = 1'b0;
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      case (state_q)
         RUN: begin
            if (memPend) begin
               {stallF, stallD, stallE, stallM} = 4'b1111;
               state_d   = (WAIT_MAX <= 1) ? ERROR : MEM_WAIT;
               waitCnt_d = WC_W'(1);
            end else if (PCscr) begin
               {flushD, flushE, flushM} = 3'b111;
               state_d = FLUSH;
            end else if (loadUse) begin
               stallF = 1'b1;
               stallD = 1'b1;
               flushE = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               waitCnt_d = '0;
               if (PCscr) begin
                  {flushD, flushE, flushM} = 3'b111;
                  state_d = FLUSH;
               end else begin
                  state_d = RUN;
               end
            end else begin
               {stallF, stallD, stallE, stallM} = 4'b1111;
               waitCnt_d = waitCnt_q + WC_W'(1);
               if (waitCnt_q == WC_W'(WAIT_MAX - 1)) state_d = ERROR;
            end
         end
         FLUSH: state_d = RUN;
         ERROR: begin
            {stallF, stallD, stallE, stallM} = 4'b1111;
            timeout = 1'b1;
         end
         default: state_d = RUN;
      endcase
      if (reset) begin
         {stallF, stallD, stallE, stallM} = 4'b0000;
         {flushD, flushE, flushM}         = 3'b111;
         timeout                          = 1'b0;
      end
   end

   // State, wait counter and saturating performance counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= RUN;
         waitCnt_q  <= '0;
         stallCnt_q <= '0;
         flushCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         if (stallF && (stallCnt_q != {CNT_W{1'b1}})) stallCnt_q <= stallCnt_q + CNT_W'(1);
         if (flushD && (flushCnt_q != {CNT_W{1'b1}})) flushCnt_q <= flushCnt_q + CNT_W'(1);
      end
   end

   assign stall_count = stallCnt_q;
   assign flush_count = flushCnt_q;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer (CNT_W=4, WAIT_MAX=4): each step
// pushes its expected outputs and counter values, then pops and compares them.
module tb_pipeline_hazard_sequencer;

   localparam int CNT_W    = 4;
   localparam int WAIT_MAX = 4;

   // Output patterns packed as {stallF,stallD,stallE,stallM,flushD,flushE,flushM,timeout}
   localparam logic [7:0] P_RESET  = 8'b0000_1110;
   localparam logic [7:0] P_FREEZE = 8'b1111_0000;
   localparam logic [7:0] P_FLUSH  = 8'b0000_1110;
   localparam logic [7:0] P_LU     = 8'b1100_0100;
   localparam logic [7:0] P_ZERO   = 8'b0000_0000;
   localparam logic [7:0] P_ERR    = 8'b1111_0001;

   typedef struct packed {
      logic [7:0]       outs;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
   } exp_t;

   logic             clock;
   logic             reset;
   logic             memReadE;
   logic [4:0]       write_regE;
   logic [4:0]       read_reg1D;
   logic [4:0]       read_reg2D;
   logic             memReadM;
   logic             memWriteM;
   logic             mem_ready;
   logic             PCscr;
   logic             stallF, stallD, stallE, stallM;
   logic             flushD, flushE, flushM, timeout;
   logic [CNT_W-1:0] stall_count, flush_count;

   exp_t             expQ[$];
   int               checks   = 0;
   int               failures = 0;
   int               modelStall = 0;
   int               modelFlush = 0;
   localparam int    CNT_MAX = (1 << CNT_W) - 1;

   pipeline_hazard_sequencer #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
      .clock       (clock),
      .reset       (reset),
      .memReadE    (memReadE),
      .write_regE  (write_regE),
      .read_reg1D  (read_reg1D),
      .read_reg2D  (read_reg2D),
      .memReadM    (memReadM),
      .memWriteM   (memWriteM),
      .mem_ready   (mem_ready),
      .PCscr       (PCscr),
      .stallF      (stallF),
      .stallD      (stallD),
      .stallE      (stallE),
      .stallM      (stallM),
      .flushD      (flushD),
      .flushE      (flushE),
      .flushM      (flushM),
      .timeout     (timeout),
      .stall_count (stall_count),
      .flush_count (flush_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pops the oldest expectation and compares both control outputs and counters.
   task automatic checkOutput(input string tag);
      exp_t       e;
      logic [7:0] obsOuts;
      if (expQ.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s scoreboard empty observed=none required=entry", tag);
         return;
      end
      e = expQ.pop_front();
      obsOuts = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, timeout};
      checks++;
      assert (obsOuts === e.outs) else begin
         failures++;
         $error("[TB] FAIL %s outputs observed=%b required=%b", tag, obsOuts, e.outs);
      end
      checks++;
      assert ({stall_count, flush_count} === {e.sc, e.fc}) else begin
         failures++;
         $error("[TB] FAIL %s counters observed=%0d/%0d required=%0d/%0d",
                tag, stall_count, flush_count, e.sc, e.fc);
      end
   endtask

   // Drives one cycle of inputs, queues its expectation, checks mid-cycle,
   // advances the counter model and moves to the next cycle.
   task automatic applyStimulus(input logic rst, input logic mrE, input logic [4:0] wrE,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic mrM, input logic mwM, input logic rdy,
                                input logic pc, input logic [7:0] expOuts,
                                input string tag);
      exp_t e;
      reset      = rst;
      memReadE   = mrE;
      write_regE = wrE;
      read_reg1D = r1;
      read_reg2D = r2;
      memReadM   = mrM;
      memWriteM  = mwM;
      mem_ready  = rdy;
      PCscr      = pc;
      e.outs = expOuts;
      e.sc   = CNT_W'(modelStall);
      e.fc   = CNT_W'(modelFlush);
      expQ.push_back(e);
      #2;
      checkOutput(tag);
      if (rst) begin
         modelStall = 0;
         modelFlush = 0;
      end else begin
         if (expOuts[7] && modelStall < CNT_MAX) modelStall++;
         if (expOuts[3] && modelFlush < CNT_MAX) modelFlush++;
      end
      @(negedge clock);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; memReadE = 1'b0; write_regE = '0; read_reg1D = '0; read_reg2D = '0;
      memReadM = 1'b0; memWriteM = 1'b0; mem_ready = 1'b0; PCscr = 1'b0;
      @(negedge clock);

      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, P_RESET, "reset0");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, P_RESET, "reset1");

      // load-use on rs1, then the load has moved on
      applyStimulus(0, 1, 5, 5, 0, 0, 0, 0, 0, P_LU,   "lu_rs1");
      applyStimulus(0, 0, 5, 5, 0, 0, 0, 0, 0, P_ZERO, "lu_done");
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, P_ZERO, "lu_x0");
      applyStimulus(0, 1, 7, 1, 7, 0, 0, 0, 0, P_LU,   "lu_rs2");
      applyStimulus(0, 1, 9, 1, 2, 0, 0, 0, 0, P_ZERO, "lu_nomatch");

      // taken branch: flush cycle, bubble cycle ignoring load-use, back in RUN
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, P_FLUSH, "br_flush");
      applyStimulus(0, 1, 5, 5, 0, 0, 0, 0, 0, P_ZERO,  "br_bubble");
      applyStimulus(0, 1, 5, 5, 0, 0, 0, 0, 0, P_LU,    "br_run");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, P_ZERO,  "br_idle");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, P_RESET, "reset2");

      // memory wait of three cycles
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, P_FREEZE, "mw_0");
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, P_FREEZE, "mw_1");
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, P_FREEZE, "mw_2");
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 0, P_ZERO,   "mw_ready");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, P_ZERO,   "mw_after");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, P_RESET,  "reset3");

      // timeout on a store that never completes
      for (int i = 0; i < WAIT_MAX; i++)
         applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, P_FREEZE, $sformatf("to_wait%0d", i));
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, P_ERR,   "to_err0");
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, P_ERR,   "to_err1");
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, P_ERR,   "to_sticky");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, P_RESET, "to_reset");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, P_ZERO,  "to_cleared");

      // mem_pend, branch and load-use together; flush applied on completion
      applyStimulus(0, 1, 3, 3, 0, 1, 0, 0, 1, P_FREEZE, "pri_0");
      applyStimulus(0, 1, 3, 3, 0, 1, 0, 0, 1, P_FREEZE, "pri_1");
      applyStimulus(0, 1, 3, 3, 0, 1, 0, 1, 1, P_FLUSH,  "pri_ready");
      applyStimulus(0, 1, 3, 3, 0, 0, 0, 0, 0, P_ZERO,   "pri_bubble");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, P_ZERO,   "pri_idle");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, P_RESET,  "reset4");

      // twenty load-use cycles saturate the 4-bit stall counter
      for (int i = 0; i < 20; i++)
         applyStimulus(0, 1, 6, 6, 6, 0, 0, 0, 0, P_LU, $sformatf("sat_%0d", i));
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, P_ZERO, "sat_hold");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
